// File: rtl/registrador_pkg.sv
// Shared types and helpers for the universal register and its one-position shifter.
package registrador_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_CLR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_SHR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_ASR  = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // One extra bit so a count equal to (or above) WIDTH is representable.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic is_shift_op(input op_t op);
        return op >= OP_SHL;
    endfunction

endpackage

// File: rtl/registrador_deslocador.sv
// Combinational one-position shifter shared by the single-op and multi-cycle paths.
module deslocador
    import registrador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  op_t              op,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (op)
            OP_SHL: begin
                next_value = {value[WIDTH-2:0], ser_in};
                out_bit    = value[WIDTH-1];
            end
            OP_SHR: begin
                next_value = {ser_in, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            OP_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            OP_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            OP_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/registrador_universal.sv
// Parametrised universal register: load/clear/shift/rotate per cycle, plus a
// multi-cycle "shift by Count" sequencer with Busy/Done status.
module registrador_universal
    import registrador_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       Op,
    input  logic             En,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [WIDTH-1:0] A,
    input  logic             SerIn,
    output logic [WIDTH-1:0] S,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done,
    output state_t           dbg_state
);

    // Handshake: Start is accepted in any cycle Busy is low (including the Done
    // cycle); Busy then stays high for exactly Count cycles, and Done pulses for
    // one cycle when the request retires. Degenerate requests pulse Done only.

    state_t            state;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt;
    op_t               op_in;
    op_t               sh_op;
    logic [WIDTH-1:0]  sh_next;
    logic              sh_out;

    assign op_in = op_t'(Op);
    assign sh_op = (state == ST_SHIFT) ? op_q : op_in;

    deslocador #(.WIDTH(WIDTH)) u_deslocador (
        .value      (S),
        .op         (sh_op),
        .ser_in     (SerIn),
        .next_value (sh_next),
        .out_bit    (sh_out)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_HOLD;
            cnt    <= '0;
            S      <= '0;
            SerOut <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_shift_op(op_in) && (Count != '0)) begin
                            op_q  <= op_in;
                            cnt   <= Count;
                            state <= ST_SHIFT;
                        end else begin
                            Done <= 1'b1;
                        end
                    end else if (En) begin
                        case (op_in)
                            OP_HOLD: ;
                            OP_LOAD: S <= A;
                            OP_CLR:  S <= '0;
                            default: begin
                                S      <= sh_next;
                                SerOut <= sh_out;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    S      <= sh_next;
                    SerOut <= sh_out;
                    cnt    <= cnt - CNT_W'(1);
                    // The edge applying the final shift retires the request.
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        Done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = (state == ST_SHIFT);
    assign dbg_state = state;

endmodule

// File: tb/tb_registrador_universal.sv
// Bench for registrador_universal: directed vector table, long shift-by-N runs,
// and randomized traffic against a behavioural model.
module tb_registrador_universal;
    import registrador_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [2:0]    Op = 3'd0;
    logic          En = 1'b0;
    logic          Start = 1'b0;
    logic [CW-1:0] Count = '0;
    logic [W-1:0]  A = '0;
    logic          SerIn = 1'b0;
    logic [W-1:0]  S;
    logic          SerOut;
    logic          Busy;
    logic          Done;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;

    registrador_universal #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Op        (Op),
        .En        (En),
        .Start     (Start),
        .Count     (Count),
        .A         (A),
        .SerIn     (SerIn),
        .S         (S),
        .SerOut    (SerOut),
        .Busy      (Busy),
        .Done      (Done),
        .dbg_state (dbg_state)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    int m_s   = 0;
    int m_so  = 0;
    int m_rem = 0;
    int m_op  = 0;
    int m_done = 0;

    task automatic m_apply(input int op, input int si);
        case (op)
            3: begin m_so = (m_s >> 7) & 1; m_s = ((m_s << 1) | si) & 255; end
            4: begin m_so = m_s & 1; m_s = (m_s >> 1) | (si << 7); end
            5: begin m_so = (m_s >> 7) & 1; m_s = ((m_s << 1) | m_so) & 255; end
            6: begin m_so = m_s & 1; m_s = (m_s >> 1) | (m_so << 7); end
            7: begin m_so = m_s & 1; m_s = (m_s >> 1) | (m_s & 128); end
            default: ;
        endcase
    endtask

    task automatic model_step();
        if (Reset) begin
            m_s = 0; m_so = 0; m_rem = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_rem > 0) begin
            m_apply(m_op, int'(SerIn));
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (Start) begin
            if (int'(Op) >= 3 && int'(Count) > 0) begin
                m_op  = int'(Op);
                m_rem = int'(Count);
            end else begin
                m_done = 1;
            end
        end else if (En) begin
            if (int'(Op) == 1) m_s = int'(A);
            else if (int'(Op) == 2) m_s = 0;
            else if (int'(Op) >= 3) m_apply(int'(Op), int'(SerIn));
        end
    endtask

    // ---------------- driver / checker ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] op, input logic en,
                         input logic start, input logic [CW-1:0] cnt,
                         input logic [W-1:0] a, input logic si);
        Reset = rst; Op = op; En = en; Start = start; Count = cnt; A = a; SerIn = si;
        @(posedge Clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [2:0]    op;
        logic          en;
        logic          start;
        logic [CW-1:0] cnt;
        logic [W-1:0]  a;
        logic          si;
        logic [W-1:0]  s;
        logic          so;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] op, input logic en,
                       input logic start, input logic [CW-1:0] cnt, input logic [W-1:0] a,
                       input logic si, input logic [W-1:0] s, input logic so,
                       input logic busy, input logic done);
        vec_t v;
        v.rst = rst; v.op = op; v.en = en; v.start = start; v.cnt = cnt; v.a = a;
        v.si = si; v.s = s; v.so = so; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic run_long(input string name, input logic [W-1:0] init,
                            input logic [2:0] op, input logic [CW-1:0] cnt,
                            input logic si, input logic [W-1:0] exp_s);
        int busy_cycles;
        bit got_done;
        drive(1'b0, 3'd1, 1'b1, 1'b0, '0, init, si);
        drive(1'b0, op, 1'b0, 1'b1, cnt, '0, si);
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (Busy) busy_cycles++;
            drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 4'($urandom),
                  8'($urandom), si);
            if (Done) got_done = 1'b1;
        end
        check({name, "_done_seen"}, int'(got_done), 1);
        check({name, "_busy_cycles"}, busy_cycles, int'(cnt));
        check({name, "_s"}, int'(S), int'(exp_s));
        drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        // rst op en start cnt a si | s so busy done
        add(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 8'hA5, 0, 8'hA5, 0, 0, 0);
        add(1, 1, 1, 0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 8'h81, 0, 8'h81, 0, 0, 0);
        add(0, 5, 1, 0, 0, 8'h00, 0, 8'h03, 1, 0, 0);
        add(0, 4, 1, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
        add(0, 1, 1, 0, 0, 8'h90, 0, 8'h90, 1, 0, 0);
        add(0, 7, 0, 1, 3, 8'h00, 0, 8'h90, 1, 1, 0);
        add(0, 1, 1, 0, 0, 8'h11, 0, 8'hC8, 0, 1, 0);
        add(0, 2, 1, 1, 5, 8'h22, 0, 8'hE4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'hF2, 0, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'hF2, 0, 0, 0);
        add(0, 2, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 4, 0, 1, 8, 8'h00, 1, 8'h00, 0, 1, 0);
        add(0, 1, 1, 1, 3, 8'h55, 1, 8'h80, 0, 1, 0);
        add(0, 2, 0, 0, 1, 8'hAA, 1, 8'hC0, 0, 1, 0);
        add(0, 1, 1, 1, 3, 8'h55, 1, 8'hE0, 0, 1, 0);
        add(0, 3, 0, 0, 1, 8'hAA, 1, 8'hF0, 0, 1, 0);
        add(0, 1, 1, 1, 3, 8'h55, 1, 8'hF8, 0, 1, 0);
        add(0, 5, 1, 0, 1, 8'hAA, 1, 8'hFC, 0, 1, 0);
        add(0, 1, 1, 1, 3, 8'h55, 1, 8'hFE, 0, 1, 0);
        add(0, 2, 1, 0, 1, 8'hAA, 1, 8'hFF, 0, 0, 1);
        add(0, 1, 1, 0, 0, 8'h3C, 0, 8'h3C, 0, 0, 0);
        add(0, 3, 0, 1, 0, 8'h00, 0, 8'h3C, 0, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0);
        add(0, 1, 0, 1, 4, 8'hFF, 0, 8'h3C, 0, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 0);
        add(0, 3, 0, 1, 5, 8'h00, 0, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h78, 0, 1, 0);
        add(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 3, 0, 1, 2, 8'h00, 1, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 1, 8'h03, 0, 0, 1);
        add(0, 6, 0, 1, 1, 8'h00, 0, 8'h03, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h81, 1, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 0, 8'h81, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].en, vecs[i].start, vecs[i].cnt,
                  vecs[i].a, vecs[i].si);
            check($sformatf("vec%0d_s", i), int'(S), int'(vecs[i].s));
            check($sformatf("vec%0d_serout", i), int'(SerOut), int'(vecs[i].so));
            check($sformatf("vec%0d_busy", i), int'(Busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), int'(Done), int'(vecs[i].done));
        end

        // Counts at and above WIDTH saturate or wrap.
        run_long("asr15_pos", 8'h40, 3'd7, 4'd15, 1'b0, 8'h00);
        run_long("asr12_neg", 8'h80, 3'd7, 4'd12, 1'b0, 8'hFF);
        run_long("shl12_fill", 8'h81, 3'd3, 4'd12, 1'b1, 8'hFF);
        run_long("rol9_wrap", 8'hA5, 3'd5, 4'd9, 1'b0, 8'h4B);
        run_long("shr8_fill", 8'h00, 3'd4, 4'd8, 1'b1, 8'hFF);

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  8'($urandom), 1'($urandom));
            check("rnd_s", int'(S), m_s);
            check("rnd_serout", int'(SerOut), m_so);
            check("rnd_busy", int'(Busy), int'(m_rem > 0));
            check("rnd_done", int'(Done), m_done);
            check("rnd_busy_and_done", int'(Busy && Done), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
